// File: rtl/rv32i_instr_decoder.sv
// rv32i_instr_decoder: registered RV32I field/format/immediate decoder with a 2-entry skid buffer and saturating counters
module rv32i_instr_decoder #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [31:0]        in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic [6:0]         out_opcode,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic [2:0]         out_funct3,
    output logic [6:0]         out_funct7,
    output logic [2:0]         out_fmt,
    output logic [31:0]        out_imm,
    output logic               out_illegal,
    output logic [COUNT_W-1:0] decoded_count,
    output logic [COUNT_W-1:0] illegal_count
);
    localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                           FMT_U = 3'd4, FMT_J = 3'd5, FMT_NONE = 3'd7;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        illegal;
    } entry_t;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    localparam entry_t CLEAR = '{pc: 32'd0, instr: 32'd0, fmt: FMT_NONE, imm: 32'd0, illegal: 1'b0};
    state_t state, state_n;
    entry_t main_q, skid_q, dec;
    logic rdy_q, accept, drain, load_main, load_skid, shift;
    logic [6:0] op, f7;
    logic [2:0] f3, fmt;
    logic ill;
    assign op = in_instr[6:0];
    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];
    always_comb begin
        fmt = FMT_NONE;
        ill = 1'b0;
        case (op)
            7'b0110011: begin
                fmt = FMT_R;
                ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            7'b0010011: begin
                fmt = FMT_I;
                ill = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
            end
            7'b0000011: begin
                fmt = FMT_I;
                ill = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
            end
            7'b1100111: begin
                fmt = FMT_I;
                ill = f3 != 3'b000;
            end
            7'b0100011: begin
                fmt = FMT_S;
                ill = f3 > 3'b010;
            end
            7'b1100011: begin
                fmt = FMT_B;
                ill = f3 == 3'b010 || f3 == 3'b011;
            end
            7'b0110111, 7'b0010111: fmt = FMT_U;
            7'b1101111: fmt = FMT_J;
            default: ill = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) ill = 1'b1;
        if (ill) fmt = FMT_NONE;
    end
    always_comb begin
        dec.pc = in_pc;
        dec.instr = in_instr;
        dec.fmt = fmt;
        dec.illegal = ill;
        dec.imm = fmt == FMT_I ? {{20{in_instr[31]}}, in_instr[31:20]} :
                  fmt == FMT_S ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
                  fmt == FMT_B ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
                  fmt == FMT_U ? {in_instr[31:12], 12'd0} :
                  fmt == FMT_J ? {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
                  32'd0;
    end
    assign in_ready  = rdy_q;
    assign out_valid = state != EMPTY;
    assign accept    = in_valid && rdy_q;
    assign drain     = out_valid && out_ready;
    always_comb begin
        state_n = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        shift = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                state_n = ONE;
                load_main = 1'b1;
            end
            ONE: if (accept && drain) begin
                load_main = 1'b1;
            end else if (accept) begin
                state_n = TWO;
                load_skid = 1'b1;
            end else if (drain) begin
                state_n = EMPTY;
            end
            TWO: if (drain) begin
                state_n = ONE;
                shift = 1'b1;
            end
            default: state_n = EMPTY;
        endcase
    end
    // in_ready is registered from the next state so it never follows out_ready combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            rdy_q <= 1'b0;
            main_q <= CLEAR;
            skid_q <= CLEAR;
            decoded_count <= '0;
            illegal_count <= '0;
        end else begin
            state <= state_n;
            rdy_q <= state_n != TWO;
            main_q <= load_main ? dec : shift ? skid_q : main_q;
            skid_q <= load_skid ? dec : skid_q;
            if (drain && !(&decoded_count)) decoded_count <= decoded_count + COUNT_W'(1);
            if (drain && main_q.illegal && !(&illegal_count)) illegal_count <= illegal_count + COUNT_W'(1);
        end
    end
    assign out_pc      = main_q.pc;
    assign out_opcode  = main_q.instr[6:0];
    assign out_rd      = main_q.instr[11:7];
    assign out_funct3  = main_q.instr[14:12];
    assign out_rs1     = main_q.instr[19:15];
    assign out_rs2     = main_q.instr[24:20];
    assign out_funct7  = main_q.instr[31:25];
    assign out_fmt     = main_q.fmt;
    assign out_imm     = main_q.imm;
    assign out_illegal = main_q.illegal;
endmodule

// File: tb/tb_rv32i_instr_decoder.sv
// tb_rv32i_instr_decoder: directed vector table plus backpressure, throughput and async-reset sequences
module tb_rv32i_instr_decoder;
    localparam int CW = 4;
    logic clk, reset, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [6:0] out_opcode, out_funct7;
    logic [4:0] out_rd, out_rs1, out_rs2;
    logic [2:0] out_funct3, out_fmt;
    logic [CW-1:0] decoded_count, illegal_count;
    int tests = 0, fails = 0;

    rv32i_instr_decoder #(.COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_fmt(out_fmt), .out_imm(out_imm), .out_illegal(out_illegal),
        .decoded_count(decoded_count), .illegal_count(illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
    } vec_t;
    vec_t v[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int n_ill;
        v[0]  = '{32'h00A00093, 3'd1, 5'd1,  5'd0, 5'd10, 3'd0, 7'h00, 32'h0000000A, 1'b0};
        v[1]  = '{32'hFFD00113, 3'd1, 5'd2,  5'd0, 5'd29, 3'd0, 7'h7F, 32'hFFFFFFFD, 1'b0};
        v[2]  = '{32'h00402023, 3'd2, 5'd0,  5'd0, 5'd4,  3'd2, 7'h00, 32'h00000000, 1'b0};
        v[3]  = '{32'h00F08463, 3'd3, 5'd8,  5'd1, 5'd15, 3'd0, 7'h00, 32'h00000008, 1'b0};
        v[4]  = '{32'h008008EF, 3'd5, 5'd17, 5'd0, 5'd8,  3'd0, 7'h00, 32'h00000008, 1'b0};
        v[5]  = '{32'h12345037, 3'd4, 5'd0,  5'd8, 5'd3,  3'd5, 7'h09, 32'h12345000, 1'b0};
        v[6]  = '{32'h00000000, 3'd7, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h00000000, 1'b1};
        v[7]  = '{32'h40001033, 3'd7, 5'd0,  5'd0, 5'd0,  3'd1, 7'h20, 32'h00000000, 1'b1};
        v[8]  = '{32'h40000033, 3'd0, 5'd0,  5'd0, 5'd0,  3'd0, 7'h20, 32'h00000000, 1'b0};
        v[9]  = '{32'h40005013, 3'd1, 5'd0,  5'd0, 5'd0,  3'd5, 7'h20, 32'h00000400, 1'b0};
        v[10] = '{32'h02001013, 3'd7, 5'd0,  5'd0, 5'd0,  3'd1, 7'h01, 32'h00000000, 1'b1};
        v[11] = '{32'h00003003, 3'd7, 5'd0,  5'd0, 5'd0,  3'd3, 7'h00, 32'h00000000, 1'b1};
        v[12] = '{32'h00002063, 3'd7, 5'd0,  5'd0, 5'd0,  3'd2, 7'h00, 32'h00000000, 1'b1};
        v[13] = '{32'h00A00091, 3'd7, 5'd1,  5'd0, 5'd10, 3'd0, 7'h00, 32'h00000000, 1'b1};
        v[14] = '{32'h00002067, 3'd7, 5'd0,  5'd0, 5'd0,  3'd2, 7'h00, 32'h00000000, 1'b1};
        v[15] = '{32'hFE112E23, 3'd2, 5'd28, 5'd2, 5'd1,  3'd2, 7'h7F, 32'hFFFFFFFC, 1'b0};
        v[16] = '{32'hFE000EE3, 3'd3, 5'd29, 5'd0, 5'd0,  3'd0, 7'h7F, 32'hFFFFFFFC, 1'b0};

        reset = 1'b1;
        in_valid = 1'b0;
        in_instr = 32'd0;
        in_pc = 32'd0;
        out_ready = 1'b1;
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_fmt", 64'(out_fmt), 64'd7);
        chk("reset_data", {out_pc, out_imm}, 64'd0);
        chk("reset_counts", 64'({decoded_count, illegal_count}), 64'd0);
        tick();
        reset = 1'b0;
        chk("in_ready_low_after_deassert", 64'(in_ready), 64'd0);
        tick();
        chk("in_ready_rises", 64'(in_ready), 64'd1);

        n_ill = 0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_instr = v[i].instr;
            in_pc = 32'h1000 + 32'(i * 4);
            chk($sformatf("vec%0d_pre_valid", i), 64'(out_valid), 64'd0);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid_pc", i), {31'd0, out_valid, out_pc}, {31'd0, 1'b1, 32'h1000 + 32'(i * 4)});
            chk($sformatf("vec%0d_opcode", i), 64'(out_opcode), 64'(v[i].instr & 32'h7F));
            chk($sformatf("vec%0d_fields", i),
                64'({out_fmt, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_imm, out_illegal}),
                64'({v[i].fmt, v[i].rd, v[i].rs1, v[i].rs2, v[i].f3, v[i].f7, v[i].imm, v[i].ill}));
            if (v[i].ill) n_ill++;
            tick();
        end
        chk("decoded_count_saturated", 64'(decoded_count), 64'd15);
        chk("illegal_count", 64'(illegal_count), 64'(n_ill));

        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = v[0].instr; in_pc = 32'hA0;
        tick();
        chk("bp_first_ready", 64'(in_ready), 64'd1);
        in_instr = v[2].instr; in_pc = 32'hA4;
        tick();
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_a", 64'(out_pc), 64'hA0);
        in_instr = v[5].instr; in_pc = 32'hA8;
        tick();
        chk("bp_stable_a", {out_valid, out_fmt, out_imm, out_pc}, {1'b1, 3'd1, 32'h0A, 32'hA0});
        chk("bp_still_full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_out_b", {out_valid, out_fmt, out_pc}, {1'b1, 3'd2, 32'hA4});
        chk("bp_ready_after_drain", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_out_c", {out_valid, out_fmt, out_imm, out_pc}, {1'b1, 3'd4, 32'h12345000, 32'hA8});
        tick();
        chk("bp_empty", 64'(out_valid), 64'd0);
        chk("bp_count", 64'(decoded_count), 64'd3);

        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = v[0].instr;
        for (int k = 0; k < 10; k++) begin
            in_pc = 32'h100 + 32'(k * 4);
            tick();
            chk($sformatf("thru%0d", k), {out_valid, in_ready, out_pc}, {1'b1, 1'b1, 32'h100 + 32'(k * 4)});
        end
        in_valid = 1'b0;
        tick();
        chk("thru_count", 64'({decoded_count, illegal_count}), 64'({4'd10, 4'd0}));
        chk("thru_empty", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = v[6].instr; in_pc = 32'hB0;
        tick();
        in_pc = 32'hB4;
        tick();
        in_valid = 1'b0;
        chk("rst_pre_full", {out_valid, in_ready}, {1'b1, 1'b0});
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async_valid", {out_valid, in_ready}, 64'd0);
        chk("rst_async_counts", 64'({decoded_count, illegal_count}), 64'd0);
        chk("rst_async_data", {out_pc, out_imm}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rst_no_stale%0d", k), {out_valid, decoded_count}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
